// File: rtl/bch_encode_sched.sv
// Round-robin front end that time-shares one serial BCH encoder between R requesters,
// serialising K-bit words MSB-first and re-tagging the encoded stream with the source ID.
module bch_encode_sched #(
    parameter int N = 15,
    parameter int K = 5,
    parameter int R = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   req_valid,
    input  logic [R*K-1:0] req_data,
    output logic [R-1:0]   req_ready,
    output logic           enc_start,
    output logic           enc_data_in,
    input  logic           enc_data_out,
    input  logic           enc_first,
    input  logic           enc_last,
    output logic           out_data,
    output logic           out_valid,
    output logic           out_first,
    output logic           out_last,
    output logic [1:0]     out_id,
    output logic [15:0]    cw_count
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_MSG  = CW'(K);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [K-1:0]    shift_reg;
    logic [1:0]      pend_id_reg;
    logic [1:0]      last_grant_reg;
    logic            armed_reg;
    logic            active_reg;
    logic            out_data_reg, out_valid_reg, out_first_reg, out_last_reg;
    logic [1:0]      out_id_reg;
    logic [15:0]     cw_count_reg;

    logic [K-1:0]    req_word [R];
    logic            slot;
    logic            xfer;
    logic [R-1:0]    grant;
    logic [1:0]      grant_id;
    logic [K-1:0]    grant_word;
    int              idx;
    logic            accept_first;
    logic            in_cw;

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_word
            assign req_word[gi] = req_data[gi*K +: K];
        end
    endgenerate

    // A grant may only be issued while the encoder is free or on its final bit.
    assign slot = !reset && ((state_reg == IDLE) || (cnt_reg == CNT_LAST));

    always_comb begin
        grant      = '0;
        grant_id   = '0;
        grant_word = '0;
        idx        = 0;
        for (int i = 0; i < R; i++) begin
            idx = (int'(last_grant_reg) + 1 + i) % R;
            if (slot && (grant == '0) && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = 2'(idx);
            end
        end
        for (int i = 0; i < R; i++) begin
            grant_word = grant_word | (req_word[i] & {K{grant[i]}});
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (xfer) state_next = RUN;
            end
            RUN: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = xfer ? RUN : IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        enc_start   = (state_reg == RUN) && (cnt_reg == '0);
        enc_data_in = (state_reg == RUN) && (cnt_reg < CNT_MSG) && shift_reg[K-1];
    end

    // Only the first encoder bit following one of our starts opens a codeword,
    // so leftover encoder activity after a reset can never raise out_valid.
    assign accept_first = enc_first && armed_reg;
    assign in_cw        = accept_first || active_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg      <= '0;
            pend_id_reg    <= '0;
            last_grant_reg <= 2'(R - 1);
            armed_reg      <= 1'b0;
            active_reg     <= 1'b0;
            out_data_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_first_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            out_id_reg     <= '0;
            cw_count_reg   <= '0;
        end else begin
            if (xfer) begin
                shift_reg      <= grant_word;
                pend_id_reg    <= grant_id;
                last_grant_reg <= grant_id;
            end else if ((state_reg == RUN) && (cnt_reg < CNT_MSG)) begin
                shift_reg <= {shift_reg[K-2:0], 1'b0};
            end
            armed_reg  <= enc_start || (armed_reg && !enc_first);
            active_reg <= accept_first || (active_reg && !enc_last);
            if (accept_first) out_id_reg <= pend_id_reg;
            out_valid_reg <= in_cw;
            out_data_reg  <= in_cw && enc_data_out;
            out_first_reg <= accept_first;
            out_last_reg  <= in_cw && enc_last;
            cw_count_reg  <= cw_count_reg + {15'd0, out_last_reg};
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_first = out_first_reg;
    assign out_last  = out_last_reg;
    assign out_id    = out_id_reg;
    assign cw_count  = cw_count_reg;

endmodule

// File: tb/tb_bch_encode_sched.sv
// Bench for bch_encode_sched: behavioural BCH(15,5) encoder, plus a window/queue reference
// model of grants, serial input, tagged output and completion count, checked every cycle.
module tb_bch_encode_sched;

    localparam int N = 15;
    localparam int K = 5;
    localparam int R = 2;
    localparam logic [9:0] G_LOW = 10'h137;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [R-1:0]   req_valid = '0;
    logic [R*K-1:0] req_data = '0;
    logic [R-1:0]   req_ready;
    logic           enc_start, enc_data_in;
    logic           out_data, out_valid, out_first, out_last;
    logic [1:0]     out_id;
    logic [15:0]    cw_count;

    logic           e_do = 1'b0, e_first = 1'b0, e_last = 1'b0;
    logic [9:0]     lfsr = '0;
    int             pc = 0;

    int checks = 0;
    int errors = 0;

    bch_encode_sched #(.N(N), .K(K), .R(R)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .enc_start(enc_start), .enc_data_in(enc_data_in),
        .enc_data_out(e_do), .enc_first(e_first), .enc_last(e_last),
        .out_data(out_data), .out_valid(out_valid), .out_first(out_first),
        .out_last(out_last), .out_id(out_id), .cw_count(cw_count)
    );

    always #5 clk = ~clk;

    // Serial systematic encoder with no reset: message bits pass through, then parity.
    always @(posedge clk) begin
        if (enc_start) begin
            lfsr    <= enc_data_in ? G_LOW : 10'd0;
            e_do    <= enc_data_in;
            e_first <= 1'b1;
            e_last  <= 1'b0;
            pc      <= 1;
        end else if (pc > 0 && pc < K) begin
            lfsr    <= {lfsr[8:0], 1'b0} ^ ((enc_data_in ^ lfsr[9]) ? G_LOW : 10'd0);
            e_do    <= enc_data_in;
            e_first <= 1'b0;
            pc      <= pc + 1;
        end else if (pc >= K && pc < N) begin
            e_do    <= lfsr[9];
            lfsr    <= {lfsr[8:0], 1'b0};
            e_first <= 1'b0;
            e_last  <= (pc == N - 1);
            pc      <= pc + 1;
        end else begin
            e_do    <= 1'b0;
            e_first <= 1'b0;
            e_last  <= 1'b0;
            pc      <= 0;
        end
    end

    function automatic logic [14:0] bch_cw(input logic [4:0] m);
        logic [14:0] r;
        r = {m, 10'b0};
        for (int i = 14; i >= 10; i--)
            if (r[i]) r = r ^ (15'h537 << (i - 10));
        return {m, r[9:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int           a;
        int           id;
        logic [K-1:0] w;
        logic [N-1:0] cw;
    } item_t;

    item_t        q[$];
    item_t        it;
    int           cyc = 0;
    int           lg = R - 1;
    logic [15:0]  exp_cnt = '0;
    int           d, rr, gid;
    logic         busy, e_start, e_din, e_ov, e_of, e_ol, e_od;
    logic [1:0]   e_id;
    logic [R-1:0] e_rdy;

    // Each accepted word at cycle a owns encoder input cycles a+1..a+N and output a+3..a+N+2.
    always @(negedge clk) begin
        #3;
        if (reset) begin
            q.delete();
            lg      = R - 1;
            exp_cnt = '0;
        end else begin
            while (q.size() > 0 && cyc > q[0].a + N + 2) void'(q.pop_front());
            busy = 0; e_start = 0; e_din = 0; e_ov = 0; e_of = 0; e_ol = 0; e_od = 0; e_id = 0;
            foreach (q[j]) begin
                d = cyc - q[j].a;
                if (d >= 1 && d <= N) begin
                    e_start = (d == 1);
                    e_din   = (d <= K) ? q[j].w[K-d] : 1'b0;
                end
                if (d >= 1 && d <= N - 1) busy = 1;
                if (d >= 3 && d <= N + 2) begin
                    e_ov = 1;
                    e_of = (d == 3);
                    e_ol = (d == N + 2);
                    e_od = q[j].cw[N+2-d];
                    e_id = 2'(q[j].id);
                end
            end
            gid = -1;
            if (!busy)
                for (int i = 0; i < R; i++) begin
                    rr = (lg + 1 + i) % R;
                    if (gid < 0 && req_valid[rr]) gid = rr;
                end
            e_rdy = '0;
            if (gid >= 0) e_rdy[gid] = 1'b1;
            chk("req_ready", req_ready, e_rdy);
            chk("enc_start", enc_start, e_start);
            chk("enc_data_in", enc_data_in, e_din);
            chk("out_valid", out_valid, e_ov);
            chk("out_first", out_first, e_of);
            chk("out_last", out_last, e_ol);
            chk("out_data", out_data, e_od);
            if (e_ov) chk("out_id", out_id, e_id);
            chk("cw_count", cw_count, exp_cnt);
            if (gid >= 0) begin
                it.a  = cyc;
                it.id = gid;
                it.w  = req_data[gid*K +: K];
                it.cw = bch_cw(it.w);
                q.push_back(it);
                lg = gid;
                $display("xfer cycle=%0d id=%0d word=%b codeword=%h", cyc, gid, it.w, it.cw);
            end
            if (e_ol) exp_cnt = exp_cnt + 16'd1;
            cyc++;
        end
    end

    // Tasks return at negedge+1, which is the input drive point.
    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        if (cyc < target) chk("wait_timeout", cyc, target);
    endtask

    task automatic send_one(input int r, input logic [K-1:0] w, output int acyc);
        logic got = 1'b0;
        acyc = -1;
        req_valid[r] = 1'b1;
        req_data[r*K +: K] = w;
        for (int n = 0; n < 60 && !got; n++) begin
            #1;
            if (req_ready[r]) begin
                got  = 1'b1;
                acyc = cyc;
            end
            @(negedge clk); #1;
        end
        req_valid[r] = 1'b0;
        if (!got) chk("grant_timeout", 0, 1);
    endtask

    int a, b, c, t0;
    int gl[$];
    int gc[$];
    int sent [R];
    logic [K-1:0] words [R][4];
    logic [N-1:0] obs_cw;

    initial begin
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_enc_start", enc_start, 0);
        chk("rst_enc_data_in", enc_data_in, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_cw_count", cw_count, 0);
        reset = 1'b0;
        @(negedge clk); #1;

        // Single golden word from requester 0.
        send_one(0, 5'b10110, a);
        wait_cyc(a + 3);
        for (int i = 0; i < N; i++) begin
            obs_cw[N-1-i] = out_data;
            @(negedge clk); #1;
        end
        chk("golden_codeword", obs_cw, 15'h591E);
        wait_cyc(a + N + 4);
        chk("single_cw_count", cw_count, 1);

        // Fairness: both requesters hold valid for four words each.
        for (int r = 0; r < R; r++) begin
            sent[r] = 0;
            for (int i = 0; i < 4; i++) words[r][i] = K'($urandom);
        end
        for (int n = 0; n < 200 && (sent[0] < 4 || sent[1] < 4); n++) begin
            for (int r = 0; r < R; r++) begin
                req_valid[r] = (sent[r] < 4);
                req_data[r*K +: K] = words[r][sent[r] % 4];
            end
            #1;
            for (int r = 0; r < R; r++)
                if (req_valid[r] && req_ready[r]) begin
                    gl.push_back(r);
                    gc.push_back(cyc);
                    sent[r]++;
                end
            @(negedge clk); #1;
        end
        req_valid = '0;
        chk("fair_grant_count", gl.size(), 8);
        for (int i = 1; i < gl.size(); i++) begin
            chk("fair_alternate", gl[i], 1 - gl[i-1]);
            chk("fair_period", gc[i] - gc[i-1], N);
        end
        wait_cyc(cyc + 2 * N + 4);

        // Request raised mid-codeword must wait for the final-bit slot.
        send_one(0, K'($urandom), a);
        wait_cyc(a + 6);
        send_one(1, K'($urandom), b);
        chk("slot_grant_cycle", b, a + N);

        // After returning to idle, a new request is granted immediately.
        wait_cyc(b + N + 10);
        t0 = cyc;
        send_one(0, K'($urandom), c);
        chk("idle_grant_cycle", c, t0);
        chk("idle_start_next", enc_start, 1);
        wait_cyc(c + N + 4);

        // Random non-sticky traffic.
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < R; r++) begin
                req_valid[r] = ($urandom_range(0, 3) != 0);
                req_data[r*K +: K] = K'($urandom);
            end
            @(negedge clk); #1;
        end
        req_valid = '0;
        wait_cyc(cyc + 2 * N + 4);

        // Reset at cnt=7; the encoder keeps running with stale output.
        send_one(0, K'($urandom), a);
        wait_cyc(a + 8);
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_enc_start", enc_start, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_id", out_id, 0);
        chk("mid_rst_cw_count", cw_count, 0);
        wait_cyc(cyc + 20);

        // Reset right on the start cycle so a stale enc_first arrives afterwards.
        send_one(1, K'($urandom), a);
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        wait_cyc(cyc + 20);
        send_one(1, K'($urandom), a);
        wait_cyc(a + N + 4);
        chk("post_rst_cw_count", cw_count, 1);

        // Counter wrap from 65535.
        force dut.cw_count_reg = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        @(negedge clk); #1;
        release dut.cw_count_reg;
        wait_cyc(cyc + 2);
        chk("wrap_preload", cw_count, 16'hFFFF);
        send_one(0, K'($urandom), a);
        wait_cyc(a + N + 4);
        chk("wrap_cw_count", cw_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
